clock_enable_monitor: RTL and testbench
=======================================

Name: clock_enable_monitor

Overview:
- Consumer-side checker for single-cycle clock-enable strobes such as divider-generated enables or enables arriving from another block.
- Measures the clk-cycle spacing between consecutive en_in pulses and reports each measured period.
- Flags pulses that arrive too early or too late relative to the expected CLK_FREQ/EXPECTED_FREQ ratio.
- Asserts locked after a run of in-tolerance periods. Used in benches and as an on-chip health monitor next to enable generators.

Parameters:
- CLK_FREQ, 12_000_000: source clock frequency in Hz.
- EXPECTED_FREQ, 6_000_000: nominal enable rate in Hz. TICKS = CLK_FREQ / EXPECTED_FREQ (integer division). TICKS must be >= 2.
- TOLERANCE, 0: allowed deviation in clk cycles. Must satisfy 0 <= TOLERANCE <= TICKS-1.
- LOCK_COUNT, 4: consecutive in-range periods required to assert locked. Must be >= 1.
- Derived: MAXP = TICKS + TOLERANCE; CW = $clog2(MAXP+1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- en_in  input  1  monitored enable strobe, synchronous to clk.
- period  output  CW  last measured spacing in clk cycles.
- period_valid  output  1  one-cycle pulse: period updated.
- too_early  output  1  one-cycle pulse: spacing < TICKS-TOLERANCE.
- too_late  output  1  one-cycle pulse: no pulse within MAXP cycles.
- locked  output  1  level: LOCK_COUNT consecutive in-range periods seen.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; internal counter cnt=0; match count mcnt=0.
  - Outputs: period=0, period_valid=0, too_early=0, too_late=0, locked=0.
  - Reset overrides everything, including a mid-measurement or locked state.
- All outputs are registered. Every pulse output appears exactly one cycle after the en_in sample that caused it. Pulse outputs are 0 in every other cycle.
- IDLE:
  - en_in=1: cnt<=1, go to MEASURE. No period, period_valid or flag output (no reference edge exists yet).
  - en_in=0: remain in IDLE.
- MEASURE and LOCKED: cnt counts clk cycles since the last accepted pulse. It increments by 1 each cycle with en_in=0.
- en_in=1 in MEASURE or LOCKED:
  - Always: period<=cnt, period_valid<=1, cnt<=1 (the strobe starts the next period).
  - cnt < TICKS-TOLERANCE: too_early<=1, mcnt<=0, locked<=0, state goes to MEASURE.
  - TICKS-TOLERANCE <= cnt <= MAXP: mcnt<=mcnt+1, saturating at LOCK_COUNT. When the new mcnt equals LOCK_COUNT: locked<=1, state goes to LOCKED. locked rises in the same cycle as period_valid.
- en_in=0 with cnt==MAXP in MEASURE or LOCKED (timeout):
  - too_late<=1, mcnt<=0, locked<=0, cnt<=0, state goes to IDLE.
  - The next en_in is treated as a fresh reference edge.
- en_in=1 in the same cycle cnt==MAXP counts as in range; no timeout.
- cnt never exceeds MAXP, so no wrap-around is possible.
- Back-to-back en_in (spacing 1) is a legal input. It yields period=1 and, because TICKS >= 2 and TOLERANCE <= TICKS-1, is flagged too_early whenever TICKS-TOLERANCE > 1.
- Simultaneous events:
  - too_early and too_late are mutually exclusive.
  - period_valid coincides only with too_early or with an in-range result, never with too_late.
- en_in held high continuously: each cycle is treated as a pulse of spacing 1.

Test Plan:
1. Defaults (TICKS=2, TOL=0, LOCK_COUNT=4); rst_n low 3 cycles, then en_in every 2nd cycle -> no outputs on the first pulse; period=2 with period_valid on each later pulse; locked=1 one cycle after the 5th pulse; too_early and too_late stay 0.
2. CLK_FREQ=12M, EXPECTED_FREQ=1M (TICKS=12), TOL=1; lock up, then a pulse at spacing 10 -> period=10, too_early=1, locked=0 in the same cycle; next 4 pulses at spacing 11, 13, 12, 12 -> locked=1 after the 4th.
3. Same config, locked; stop en_in -> too_late pulses exactly 13 cycles after the last pulse's cnt<=1 cycle (cnt reaches 13); locked drops with it; next pulse produces no period_valid.
4. Same config, pulse arrives exactly at spacing 13 -> no too_late; period=13; mcnt increments.
5. Defaults, locked; assert rst_n=0 for 1 cycle mid-period -> all outputs 0 next cycle; next pulse is a reference only, with no period_valid.
6. Defaults; en_in held at 1 for 6 cycles after a reference -> period=1 and too_early=1 every cycle; locked stays 0.

Source files
------------

// File: rtl/clock_enable_monitor_if.sv
// Bundles the monitored strobe with the monitor's measurement and status outputs.
// The master drives en_in; the monitor (slave) drives everything else.
interface clock_enable_monitor_if #(
    parameter int CW = 2
) ();
    logic          en_in;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          too_early;
    logic          too_late;
    logic          locked;

    modport master (
        output en_in,
        input  period, period_valid, too_early, too_late, locked
    );

    modport slave (
        input  en_in,
        output period, period_valid, too_early, too_late, locked
    );
endinterface

// File: rtl/clock_enable_monitor.sv
// Measures clk-cycle spacing between en_in strobes, flags early/late strobes and
// reports lock after LOCK_COUNT consecutive in-tolerance periods.
module clock_enable_monitor #(
    parameter int CLK_FREQ      = 12_000_000,
    parameter int EXPECTED_FREQ = 6_000_000,
    parameter int TOLERANCE     = 0,
    parameter int LOCK_COUNT    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    clock_enable_monitor_if.slave   mon
);
    localparam int TICKS = CLK_FREQ / EXPECTED_FREQ;
    localparam int MAXP  = TICKS + TOLERANCE;
    localparam int LOWER = TICKS - TOLERANCE;
    localparam int CW    = $clog2(MAXP + 1);
    localparam int MW    = $clog2(LOCK_COUNT + 1);

    localparam logic [CW-1:0] MAXP_C  = CW'(MAXP);
    localparam logic [CW-1:0] LOWER_C = CW'(LOWER);
    localparam logic [MW-1:0] LC_C    = MW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [MW-1:0] mcnt_q;
    logic [MW-1:0] mcnt_d;
    logic [CW-1:0] period_q;
    logic          period_valid_q;
    logic          too_early_q;
    logic          too_late_q;
    logic          locked_q;

    // Saturating successor of the match count, used on an in-range strobe.
    always_comb begin
        mcnt_d = mcnt_q;
        if (mcnt_q != LC_C) begin
            mcnt_d = mcnt_q + MW'(1);
        end else begin
            mcnt_d = LC_C;
        end
    end

    // Measurement FSM with all outputs registered; pulse outputs default low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            mcnt_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            too_early_q    <= 1'b0;
            too_late_q     <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            too_early_q    <= 1'b0;
            too_late_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mon.en_in) begin
                        cnt_q   <= CW'(1);
                        state_q <= ST_MEASURE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (mon.en_in) begin
                        period_q       <= cnt_q;
                        period_valid_q <= 1'b1;
                        cnt_q          <= CW'(1);
                        if (cnt_q < LOWER_C) begin
                            too_early_q <= 1'b1;
                            mcnt_q      <= '0;
                            locked_q    <= 1'b0;
                            state_q     <= ST_MEASURE;
                        end else begin
                            mcnt_q <= mcnt_d;
                            if (mcnt_d == LC_C) begin
                                locked_q <= 1'b1;
                                state_q  <= ST_LOCKED;
                            end else begin
                                state_q  <= ST_MEASURE;
                            end
                        end
                    end else if (cnt_q == MAXP_C) begin
                        // No strobe within the window: drop lock, wait for a fresh reference.
                        too_late_q <= 1'b1;
                        mcnt_q     <= '0;
                        locked_q   <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    mcnt_q   <= '0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign mon.period       = period_q;
    assign mon.period_valid = period_valid_q;
    assign mon.too_early    = too_early_q;
    assign mon.too_late     = too_late_q;
    assign mon.locked       = locked_q;
endmodule

// File: tb/tb_clock_enable_monitor.sv
// Randomized bench: two monitor configurations checked against a timestamp-based
// reference model of strobe spacing, tolerance window and lock run length.
module tb_clock_enable_monitor;
    localparam int NCYC = 6000;

    logic clk;
    logic rst_n;

    clock_enable_monitor_if #(.CW(2)) if0 ();
    clock_enable_monitor_if #(.CW(4)) if1 ();

    // u0: TICKS=2, TOL=0 (window 2..2); u1: TICKS=12, TOL=1 (window 11..13)
    clock_enable_monitor u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (if0.slave)
    );

    clock_enable_monitor #(
        .CLK_FREQ      (12_000_000),
        .EXPECTED_FREQ (1_000_000),
        .TOLERANCE     (1),
        .LOCK_COUNT    (4)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int lower_w[2] = '{2, 11};
    int maxp_w[2]  = '{2, 13};
    int lock_n     = 4;

    // Reference model state: timestamp of last accepted strobe and in-range run length.
    bit have_ref[2];
    int last_t[2];
    int run_len[2];
    int e_per[2];
    bit e_pv[2], e_te[2], e_tl[2], e_lk[2];

    int gap[2];
    int burst[2];

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick_gap(input int d);
        int r;
        r = int'($urandom_range(99, 0));
        if (r < 4) begin
            burst[d] = 5;
            return 1;
        end else if (r < 70) begin
            return int'($urandom_range(maxp_w[d], lower_w[d]));
        end else if (r < 85) begin
            return (lower_w[d] > 1) ? int'($urandom_range(lower_w[d] - 1, 1)) : 1;
        end else begin
            return int'($urandom_range(maxp_w[d] + 4, maxp_w[d] + 1));
        end
    endfunction

    function automatic bit next_en(input int d);
        if (gap[d] <= 1) begin
            if (burst[d] > 0) begin
                burst[d]--;
                gap[d] = 1;
            end else begin
                gap[d] = pick_gap(d);
            end
            return 1'b1;
        end else begin
            gap[d]--;
            return 1'b0;
        end
    endfunction

    task automatic model_step(input int d, input bit en, input bit rst_low, input int t);
        int sp;
        e_pv[d] = 1'b0;
        e_te[d] = 1'b0;
        e_tl[d] = 1'b0;
        if (rst_low) begin
            have_ref[d] = 1'b0;
            run_len[d]  = 0;
            e_per[d]    = 0;
            e_lk[d]     = 1'b0;
        end else if (!have_ref[d]) begin
            if (en) begin
                have_ref[d] = 1'b1;
                last_t[d]   = t;
            end
        end else begin
            sp = t - last_t[d];
            if (en) begin
                e_per[d]  = sp;
                e_pv[d]   = 1'b1;
                last_t[d] = t;
                if (sp < lower_w[d]) begin
                    e_te[d]    = 1'b1;
                    run_len[d] = 0;
                end else begin
                    run_len[d] = (run_len[d] + 1 > lock_n) ? lock_n : run_len[d] + 1;
                end
                e_lk[d] = (run_len[d] == lock_n);
            end else if (sp == maxp_w[d]) begin
                e_tl[d]     = 1'b1;
                have_ref[d] = 1'b0;
                run_len[d]  = 0;
                e_lk[d]     = 1'b0;
            end
        end
    endtask

    initial begin
        bit en0, en1, rl;
        rst_n     = 1'b0;
        if0.en_in = 1'b0;
        if1.en_in = 1'b0;
        for (int d = 0; d < 2; d++) begin
            have_ref[d] = 1'b0;
            last_t[d]   = 0;
            run_len[d]  = 0;
            e_per[d]    = 0;
            e_pv[d]     = 1'b0;
            e_te[d]     = 1'b0;
            e_tl[d]     = 1'b0;
            e_lk[d]     = 1'b0;
            gap[d]      = int'($urandom_range(5, 1));
            burst[d]    = 0;
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_val("u0.period",       int'(if0.period),       e_per[0]);
            check_val("u0.period_valid", int'(if0.period_valid), int'(e_pv[0]));
            check_val("u0.too_early",    int'(if0.too_early),    int'(e_te[0]));
            check_val("u0.too_late",     int'(if0.too_late),     int'(e_tl[0]));
            check_val("u0.locked",       int'(if0.locked),       int'(e_lk[0]));
            check_val("u1.period",       int'(if1.period),       e_per[1]);
            check_val("u1.period_valid", int'(if1.period_valid), int'(e_pv[1]));
            check_val("u1.too_early",    int'(if1.too_early),    int'(e_te[1]));
            check_val("u1.too_late",     int'(if1.too_late),     int'(e_tl[1]));
            check_val("u1.locked",       int'(if1.locked),       int'(e_lk[1]));

            rl  = (cyc < 3) || ($urandom_range(399, 0) == 0);
            en0 = next_en(0);
            en1 = next_en(1);
            rst_n     = ~rl;
            if0.en_in = en0;
            if1.en_in = en1;
            model_step(0, en0, rl, cyc);
            model_step(1, en1, rl, cyc);
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
